// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage issuing loads, stores and call/ret stack traffic over req/ack, stalling upstream while busy.
module mem_access_stage #(
  parameter logic [31:0] STACK_TOP = 32'h0000_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_in,
  input  logic        MemWrite_in,
  input  logic        MemRead_in,
  input  logic        MemToReg_in,
  input  logic        MemSrc_in,
  input  logic        call_in,
  input  logic        ret_in,
  input  logic [4:0]  DestReg_in,
  input  logic [31:0] ALU_addr_in,
  input  logic [31:0] NON_ALU_addr_in,
  input  logic [31:0] MemWrite_data_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_out,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic [4:0]  DestReg_out,
  output logic [31:0] alu_data_out,
  output logic [31:0] mem_data_out,
  output logic        ret_valid_out,
  output logic [31:0] ret_addr_out,
  output logic [31:0] sp_out
);
  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic [1:0] {OP_CALL, OP_RET, OP_WRITE, OP_READ} op_t;
  state_t      state;
  op_t         op_l, op_sel;
  logic        mem_op, rw_l, m2r_l;
  logic [4:0]  dest_l;
  logic [31:0] alu_l, data_addr;
  assign mem_op    = call_in | ret_in | MemWrite_in | MemRead_in;
  assign data_addr = MemSrc_in ? NON_ALU_addr_in : ALU_addr_in;
  assign op_sel    = call_in ? OP_CALL : ret_in ? OP_RET : MemWrite_in ? OP_WRITE : OP_READ;
  assign stall_out = rst & ((state == IDLE) ? mem_op : ~dmem_ack);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      op_l          <= OP_READ;
      rw_l          <= 1'b0;
      m2r_l         <= 1'b0;
      dest_l        <= '0;
      alu_l         <= '0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      RegWrite_out  <= 1'b0;
      MemToReg_out  <= 1'b0;
      DestReg_out   <= '0;
      alu_data_out  <= '0;
      mem_data_out  <= '0;
      ret_valid_out <= 1'b0;
      ret_addr_out  <= '0;
      sp_out        <= STACK_TOP;
    end else if (state == IDLE) begin
      ret_valid_out <= 1'b0;
      if (mem_op) begin
        state        <= WAIT;
        op_l         <= op_sel;
        rw_l         <= RegWrite_in;
        m2r_l        <= MemToReg_in;
        dest_l       <= DestReg_in;
        alu_l        <= ALU_addr_in;
        dmem_req     <= 1'b1;
        dmem_we      <= op_sel == OP_CALL || op_sel == OP_WRITE;
        dmem_addr    <= op_sel == OP_CALL ? sp_out - 32'd1 : op_sel == OP_RET ? sp_out : data_addr;
        dmem_wdata   <= op_sel == OP_CALL ? NON_ALU_addr_in : MemWrite_data_in;
        RegWrite_out <= 1'b0;
      end else begin
        RegWrite_out <= RegWrite_in;
        MemToReg_out <= MemToReg_in;
        DestReg_out  <= DestReg_in;
        alu_data_out <= ALU_addr_in;
      end
    end else if (dmem_ack) begin
      state         <= IDLE;
      dmem_req      <= 1'b0;
      RegWrite_out  <= rw_l;
      MemToReg_out  <= m2r_l;
      DestReg_out   <= dest_l;
      alu_data_out  <= alu_l;
      ret_valid_out <= op_l == OP_RET;
      if (op_l == OP_READ) mem_data_out <= dmem_rdata;
      if (op_l == OP_RET) ret_addr_out <= dmem_rdata;
      if (op_l == OP_CALL) sp_out <= sp_out - 32'd1;
      if (op_l == OP_RET) sp_out <= sp_out + 32'd1;
    end else begin
      RegWrite_out  <= 1'b0;
      ret_valid_out <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed vectors for the memory stage with hand-computed expectations.
module tb_mem_access_stage;
  logic clk = 0, rst = 0;
  logic RegWrite_in, MemWrite_in, MemRead_in, MemToReg_in, MemSrc_in, call_in, ret_in;
  logic [4:0] DestReg_in;
  logic [31:0] ALU_addr_in, NON_ALU_addr_in, MemWrite_data_in;
  logic dmem_req, dmem_we, dmem_ack, stall_out, RegWrite_out, MemToReg_out, ret_valid_out;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, alu_data_out, mem_data_out, ret_addr_out, sp_out;
  logic [4:0] DestReg_out;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .RegWrite_in(RegWrite_in), .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
    .MemToReg_in(MemToReg_in), .MemSrc_in(MemSrc_in), .call_in(call_in), .ret_in(ret_in),
    .DestReg_in(DestReg_in), .ALU_addr_in(ALU_addr_in), .NON_ALU_addr_in(NON_ALU_addr_in),
    .MemWrite_data_in(MemWrite_data_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall_out(stall_out),
    .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out), .DestReg_out(DestReg_out),
    .alu_data_out(alu_data_out), .mem_data_out(mem_data_out),
    .ret_valid_out(ret_valid_out), .ret_addr_out(ret_addr_out), .sp_out(sp_out)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic next;
    @(posedge clk);
    #1;
  endtask
  task automatic clear;
    {RegWrite_in, MemWrite_in, MemRead_in, MemToReg_in, MemSrc_in, call_in, ret_in} = '0;
    DestReg_in = 0; ALU_addr_in = 0; NON_ALU_addr_in = 0; MemWrite_data_in = 0;
  endtask
  initial begin
    clear();
    dmem_ack = 0; dmem_rdata = 0;
    MemRead_in = 1;
    next(); next();
    chk("rst_stall", stall_out, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_sp", sp_out, 32'h0000_FFFF);
    chk("rst_regwrite", RegWrite_out, 0);
    clear();
    rst = 1;
    next();
    // ALU op
    RegWrite_in = 1; DestReg_in = 5; ALU_addr_in = 32'h1234; #1;
    chk("alu_stall", stall_out, 0);
    next(); clear(); #1;
    chk("alu_rw", RegWrite_out, 1);
    chk("alu_dest", DestReg_out, 5);
    chk("alu_data", alu_data_out, 32'h1234);
    chk("alu_sp", sp_out, 32'h0000_FFFF);
    chk("alu_stall1", stall_out, 0);
    next();
    chk("alu_rw_off", RegWrite_out, 0);
    // load, ack in cycle 3
    MemRead_in = 1; RegWrite_in = 1; MemToReg_in = 1; DestReg_in = 7; ALU_addr_in = 32'h40; #1;
    chk("ld_stall0", stall_out, 1);
    next();
    chk("ld_req1", dmem_req, 1);
    chk("ld_addr", dmem_addr, 32'h40);
    chk("ld_we", dmem_we, 0);
    chk("ld_stall1", stall_out, 1);
    chk("ld_bubble1", RegWrite_out, 0);
    next();
    chk("ld_req2", dmem_req, 1);
    chk("ld_stall2", stall_out, 1);
    chk("ld_bubble2", RegWrite_out, 0);
    next();
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF; #1;
    chk("ld_req3", dmem_req, 1);
    chk("ld_stall3", stall_out, 0);
    chk("ld_bubble3", RegWrite_out, 0);
    next();
    dmem_ack = 0; clear(); #1;
    chk("ld_data", mem_data_out, 32'hDEADBEEF);
    chk("ld_rw", RegWrite_out, 1);
    chk("ld_dest", DestReg_out, 7);
    chk("ld_m2r", MemToReg_out, 1);
    chk("ld_req4", dmem_req, 0);
    chk("ld_stall4", stall_out, 0);
    next();
    // call
    call_in = 1; NON_ALU_addr_in = 32'h100; #1;
    chk("call_stall", stall_out, 1);
    next();
    chk("call_req", dmem_req, 1);
    chk("call_we", dmem_we, 1);
    chk("call_addr", dmem_addr, 32'h0000_FFFE);
    chk("call_wdata", dmem_wdata, 32'h100);
    chk("call_sp_pre", sp_out, 32'h0000_FFFF);
    dmem_ack = 1; #1;
    chk("call_stall_ack", stall_out, 0);
    next();
    dmem_ack = 0; clear();
    ret_in = 1; #1;
    chk("call_sp", sp_out, 32'h0000_FFFE);
    chk("call_req_off", dmem_req, 0);
    chk("call_retv", ret_valid_out, 0);
    chk("ret_stall", stall_out, 1);
    next();
    chk("ret_req", dmem_req, 1);
    chk("ret_we", dmem_we, 0);
    chk("ret_addr_req", dmem_addr, 32'h0000_FFFE);
    next();
    dmem_ack = 1; dmem_rdata = 32'h100;
    next();
    dmem_ack = 0; dmem_rdata = 32'h7777; clear(); #1;
    chk("ret_valid", ret_valid_out, 1);
    chk("ret_addr", ret_addr_out, 32'h100);
    chk("ret_sp", sp_out, 32'h0000_FFFF);
    chk("ret_memdata", mem_data_out, 32'hDEADBEEF);
    next();
    chk("ret_valid_pulse", ret_valid_out, 0);
    // store with immediate ack
    MemWrite_in = 1; MemSrc_in = 1; NON_ALU_addr_in = 32'h80; ALU_addr_in = 32'h999; MemWrite_data_in = 32'h55;
    next();
    chk("st_req", dmem_req, 1);
    chk("st_we", dmem_we, 1);
    chk("st_addr", dmem_addr, 32'h80);
    chk("st_wdata", dmem_wdata, 32'h55);
    dmem_ack = 1;
    next();
    dmem_ack = 0; clear(); #1;
    chk("st_req_off", dmem_req, 0);
    chk("st_alu", alu_data_out, 32'h999);
    next();
    chk("st_no_repeat", dmem_req, 0);
    // priority: call beats read
    call_in = 1; MemRead_in = 1; RegWrite_in = 1; ALU_addr_in = 32'h40; NON_ALU_addr_in = 32'h200;
    next();
    chk("pri_we", dmem_we, 1);
    chk("pri_addr", dmem_addr, 32'h0000_FFFE);
    chk("pri_wdata", dmem_wdata, 32'h200);
    dmem_ack = 1; dmem_rdata = 32'h1111;
    next();
    dmem_ack = 0; clear(); #1;
    chk("pri_sp", sp_out, 32'h0000_FFFE);
    chk("pri_memdata", mem_data_out, 32'hDEADBEEF);
    next();
    // reset during WAIT
    MemRead_in = 1; RegWrite_in = 1; ALU_addr_in = 32'h44;
    next();
    chk("rw_req", dmem_req, 1);
    rst = 0; #1;
    chk("rw_req_off", dmem_req, 0);
    chk("rw_addr", dmem_addr, 0);
    chk("rw_sp", sp_out, 32'h0000_FFFF);
    chk("rw_alu", alu_data_out, 0);
    chk("rw_memdata", mem_data_out, 0);
    chk("rw_stall", stall_out, 0);
    next();
    clear(); rst = 1;
    dmem_ack = 1; dmem_rdata = 32'hCAFE; #1;
    chk("late_stall", stall_out, 0);
    next();
    dmem_ack = 0; #1;
    chk("late_rw", RegWrite_out, 0);
    chk("late_memdata", mem_data_out, 0);
    chk("late_req", dmem_req, 0);
    chk("late_sp", sp_out, 32'h0000_FFFF);
    chk("late_retv", ret_valid_out, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage of the Tronsister CPU pipeline, directly downstream of the EX/MEM pipeline register. It consumes the registered EX/MEM control and data, performs data-memory loads and stores and call/return stack pushes and pops over a req/ack handshake, and stalls the front of the pipeline while an access is outstanding. Its registered outputs form the MEM/WB boundary consumed by write-back and by the fetch unit for returns.

## Interface
- STACK_TOP, 32'h0000_FFFF, reset value of the stack pointer (empty, full-descending stack)
- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous and active-low
- RegWrite_in, MemWrite_in, MemRead_in, MemToReg_in, MemSrc_in, call_in, ret_in  in  1 each  control from EX/MEM
- DestReg_in  in  5  destination register
- ALU_addr_in, NON_ALU_addr_in, MemWrite_data_in  in  32 each  address sources and store data
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  1 = write, 0 = read, registered
- dmem_addr, dmem_wdata  out  32 each  registered request address and data
- dmem_rdata  in  32  read data, valid with dmem_ack
- dmem_ack  in  1  one-cycle completion pulse
- stall_out  out  1  combinational; holds EX/MEM and all upstream stages
- RegWrite_out, MemToReg_out  out  1 each  MEM/WB control
- DestReg_out  out  5  MEM/WB destination
- alu_data_out, mem_data_out  out  32 each  ALU result and load data
- ret_valid_out  out  1  one-cycle pulse: ret_addr_out is the popped return PC
- ret_addr_out  out  32  popped return address
- sp_out  out  32  current stack pointer

## Operation
- Memory op = call_in | ret_in | MemWrite_in | MemRead_in. If several are set, priority is call > ret > write > read.
- Data address = MemSrc_in ? NON_ALU_addr_in : ALU_addr_in.
- call: write NON_ALU_addr_in (return PC) to address sp-1; on ack, sp <= sp-1.
- ret: read address sp; on ack, sp <= sp+1, ret_addr_out <= dmem_rdata, ret_valid_out = 1 for one cycle.
- store: write MemWrite_data_in to data address. load: read data address; mem_data_out <= dmem_rdata on ack.
- sp arithmetic is 32-bit modular. No overflow or underflow detection: a call at sp=0 gives 32'hFFFF_FFFF.
- FSM IDLE:
  - Non-memory op: MEM/WB registers load from inputs at the next edge. stall_out=0.
  - Memory op: stall_out=1. Latch control, DestReg and ALU_addr_in. Register dmem_req=1 with dmem_we, dmem_addr and dmem_wdata. Go to WAIT.
- FSM WAIT:
  - Ignore all *_in ports. Hold dmem_* stable. stall_out = ~dmem_ack.
  - On dmem_ack: dmem_req <= 0, load MEM/WB from the latched values (and rdata for loads), update sp, go to IDLE.
- While stalled, and on every cycle that is not a completion, MEM/WB carries a bubble: RegWrite_out=0, ret_valid_out=0. Data outputs hold their last values.
- dmem_ack while in IDLE is ignored.

## Timing
- Non-memory op presented in cycle N: MEM/WB valid in cycle N+1.
- Memory op presented in cycle N: dmem_req is high from cycle N+1. If ack arrives in cycle N+k (k≥1), MEM/WB is valid and sp is updated in cycle N+k+1.
- stall_out is high from cycle N through cycle N+k-1 and low in cycle N+k, so EX/MEM advances exactly once at the end of cycle N+k. The same op is never reissued.
- Back-to-back memory ops: the next op is seen in IDLE in cycle N+k+1. There is at least one idle cycle between requests (dmem_req low in cycle N+k+1).
- Reset (rst=0, any time including mid-WAIT), applied immediately:
  - FSM to IDLE; the pending access is abandoned.
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
  - All MEM/WB outputs 0, ret_valid_out=0.
  - sp_out=STACK_TOP. stall_out=0 while in reset.

## Test plan
- Reset then ALU op: RegWrite_in=1, DestReg_in=5, ALU_addr_in=32'h1234 in cycle 0 -> cycle 1: RegWrite_out=1, DestReg_out=5, alu_data_out=32'h1234. stall_out never asserts. sp_out=32'h0000_FFFF.
- Load with 3-cycle memory latency: MemRead_in=1, MemSrc_in=0, ALU_addr_in=32'h40, ack with rdata 32'hDEADBEEF in cycle 3 -> dmem_req high cycles 1–3, dmem_addr=32'h40, dmem_we=0. stall_out high cycles 0–2, low in cycle 3. Cycle 4: mem_data_out=32'hDEADBEEF, RegWrite_out=1. Bubbles (RegWrite_out=0) in cycles 1–3.
- Call then ret from reset: call_in=1, NON_ALU_addr_in=32'h0000_0100 -> write to 32'h0000_FFFE, sp_out=32'h0000_FFFE after ack. Then ret_in=1 with rdata 32'h100 -> read 32'h0000_FFFE, ret_valid_out pulses one cycle with ret_addr_out=32'h100, sp_out=32'h0000_FFFF.
- Store with MemSrc_in=1, NON_ALU_addr_in=32'h80, MemWrite_data_in=32'h55 and immediate ack in cycle 1 -> one request, dmem_we=1, dmem_addr=32'h80, dmem_wdata=32'h55. Op not repeated after EX/MEM advances.
- Priority: call_in=1 and MemRead_in=1 together -> only the push is performed (dmem_we=1 to sp-1).
- Reset asserted in WAIT before ack -> dmem_req drops immediately, outputs 0, sp_out=STACK_TOP. A late dmem_ack after reset release is ignored.
